pfb_sync_sequencer: RTL
=======================

// Module: pfb_sync_sequencer
// PURPOSE
//  Sequences the PFB sync pulse and the mux-select word that software writes via the mux_sel_pfb_sync register.
//  The block takes that register's user-side word and a periodic external sync, and runs in the user_clk domain.
//  It issues aligned PFB sync pulses: one-shot on arm, forced, or free-running at a programmed period.
//  mux_sel changes only on a sync-pulse cycle, so the datapath never sees a mid-frame switch.
// PARAMETERS
//  SEL_W     4   width of mux_sel_o; taken from ctrl_word[8+SEL_W-1:8]
//  PERIOD_W  32  width of sync_period_i and of the internal countdown counter
//  CNT_W     32  width of sync_count_o
// PORTS
//  user_clk       in   1         sole clock; all logic is synchronous to its rising edge
//  user_rst_n     in   1         asynchronous reset, active-low
//  ctrl_word_i    in   32        user_data_out of the ctrl register; [0] arm, [1] force, [2] periodic_en, [8+:SEL_W] mux_sel_req
//  sync_period_i  in   PERIOD_W  pulse spacing in user_clk cycles, from a software register
//  ext_sync_i     in   1         external sync level, synchronous to user_clk
//  pfb_sync_o     out  1         registered 1-cycle sync pulse to the PFB/FFT chain
//  mux_sel_o      out  SEL_W     registered datapath mux select
//  armed_o        out  1         high while state==ARMED
//  running_o      out  1         high while state==RUN
//  sync_count_o   out  CNT_W     count of pulses issued since the last arm
// BEHAVIOUR
//  Reset: all registers clear asynchronously. The outputs pfb_sync_o, mux_sel_o, armed_o, running_o and sync_count_o go to 0.
//    The edge-detect history registers also clear, the state goes to IDLE and the countdown goes to 0.
//    A reset mid-pulse or mid-RUN drops the output immediately; no pulse is issued on release.
//  Edge detect: arm_rise, force_rise and ext_rise each mean the input is 1 now and its registered previous value is 0.
//    Level-held register bits therefore act exactly once.
//  Latency: an event sampled at edge N drives pfb_sync_o high for exactly cycle N+1.
//    mux_sel_o loads mux_sel_req at the same edge that raises pfb_sync_o.
//  FSM states: IDLE, ARMED, RUN.
//   IDLE : arm_rise -> ARMED. force_rise -> one pulse, then stay in IDLE, or go to RUN under the RUN-entry rule below.
//   ARMED: ext_rise or force_rise (one pulse even if both) -> pulse, then RUN-entry rule; otherwise wait indefinitely.
//   RUN  : the countdown decrements each cycle. At 0 it pulses and reloads sync_period_i-2, so pulses are exactly sync_period_i cycles apart.
//          arm_rise -> ARMED, with no pulse even if the countdown hits 0 that same cycle; arm wins.
//          force_rise -> immediate pulse and reload, which realigns the phase.
//          periodic_en=0 -> IDLE on the next edge, with no further pulse.
//          ext_rise is ignored in RUN.
//  RUN-entry rule: after a pulse, go to RUN if periodic_en=1 and sync_period_i>=2; otherwise go to IDLE.
//    A period of 0 or 1 is never free-running.
//  sync_period_i is sampled only at pulse/reload cycles; changes made mid-period take effect at the next reload.
//  sync_count_o: cleared on arm_rise, +1 per pulse, wraps from all-ones to 0.
//    On a simultaneous clear and increment, the clear wins.
//  ext_sync_i is not resynchronised here; the source must be in the user_clk domain.
// STRUCTURE
//  Package pfb_sync_pkg holds:
//    - the state encoding (IDLE=2'd0, ARMED=2'd1, RUN=2'd2);
//    - the ctrl bit indices (CTRL_ARM=0, CTRL_FORCE=1, CTRL_PER_EN=2, CTRL_SEL_LSB=8).
//  Sub-module rise_detect (register plus AND-NOT, async active-low reset) is instantiated three times.
//  The FSM, countdown, pulse register and counter live in the top module.
// TESTING
//  1 Reset, then ctrl=0 for 100 cycles -> pfb_sync_o=0 throughout; all outputs 0.
//  2 ctrl=0x0000_0301 (arm, sel=3), ext_sync rises at cycle 20 -> pfb_sync_o high only in cycle 21;
//    mux_sel_o=3 from cycle 21; armed_o drops; sync_count_o=1; state back to IDLE.
//  3 ctrl=0x5 (arm, periodic), period=8, ext_sync at cycle 10 -> pulses at 11, 19, 27, 35; running_o=1;
//    change period to 4 at cycle 13 -> next pulses at 19, 23, 27.
//  4 In RUN with period=8, toggle arm so its rising edge lands on the cycle the countdown hits 0 -> no pulse;
//    armed_o=1; sync_count_o=0.
//  5 In ARMED, force and ext_sync rise on the same edge -> exactly one pulse; count +1.
//    Also: period=1 with periodic_en=1 -> IDLE after the pulse.
//  6 Preload count to all-ones via forced pulses (or force the value), then pulse -> sync_count_o=0.
//    Also: assert user_rst_n low during a pulse cycle -> pfb_sync_o=0 immediately.

Source files
------------

// File: rtl/pfb_sync_pkg.sv
// Shared encodings for the PFB sync sequencer: FSM states and the ctrl-word bit map.
package pfb_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_FORCE   = 1;
  localparam int CTRL_PER_EN  = 2;
  localparam int CTRL_SEL_LSB = 8;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is high for the one cycle where level is 1 and was 0.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/pfb_sync_sequencer.sv
// Issues aligned one-cycle PFB sync pulses (one-shot, forced or periodic) and switches
// the datapath mux select only on a pulse cycle.
//
//  state | meaning
//  IDLE  | no sync source active; force still issues a single pulse
//  ARMED | waiting for the first external sync (or force) edge
//  RUN   | free-running, one pulse every sync_period_i cycles
module pfb_sync_sequencer
  import pfb_sync_pkg::*;
#(
  parameter int SEL_W    = 4,
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 32
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [31:0]         ctrl_word_i,
  input  logic [PERIOD_W-1:0] sync_period_i,
  input  logic                ext_sync_i,
  output logic                pfb_sync_o,
  output logic [SEL_W-1:0]    mux_sel_o,
  output logic                armed_o,
  output logic                running_o,
  output logic [CNT_W-1:0]    sync_count_o
);

  localparam logic [31:0] CTRL_USED = 32'h7 | (((32'h1 << SEL_W) - 32'h1) << CTRL_SEL_LSB);

  state_t              state;
  state_t              state_nxt;
  logic                pulse;
  logic                arm_rise;
  logic                force_rise;
  logic                ext_rise;
  logic                per_en;
  logic                run_ok;
  logic [SEL_W-1:0]    sel_req;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;
  logic                cnt_zero;
  logic                ctrl_unused;

  assign per_en      = ctrl_word_i[CTRL_PER_EN];
  assign sel_req     = ctrl_word_i[CTRL_SEL_LSB +: SEL_W];
  assign ctrl_unused = ^(ctrl_word_i & ~CTRL_USED);

  rise_detect u_arm_rise (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .level (ctrl_word_i[CTRL_ARM]),
    .rise  (arm_rise)
  );

  rise_detect u_force_rise (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .level (ctrl_word_i[CTRL_FORCE]),
    .rise  (force_rise)
  );

  rise_detect u_ext_rise (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .level (ext_sync_i),
    .rise  (ext_rise)
  );

  // Periods below 2 cannot free-run; they also reload as 0 so the countdown never underflows.
  assign run_ok   = per_en && (sync_period_i >= PERIOD_W'(2));
  assign reload   = (sync_period_i >= PERIOD_W'(2)) ? (sync_period_i - PERIOD_W'(2)) : '0;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pulse     = 1'b0;
    case (state)
      IDLE: begin
        if (arm_rise) begin
          state_nxt = ARMED;
        end else if (force_rise) begin
          pulse     = 1'b1;
          state_nxt = run_ok ? RUN : IDLE;
        end
      end
      ARMED: begin
        if (ext_rise || force_rise) begin
          pulse     = 1'b1;
          state_nxt = run_ok ? RUN : IDLE;
        end
      end
      RUN: begin
        if (arm_rise) begin
          state_nxt = ARMED;
        end else if (!per_en) begin
          state_nxt = IDLE;
        end else if (force_rise || (cnt_zero && !pfb_sync_o)) begin
          pulse     = 1'b1;
          state_nxt = run_ok ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reload happens in the pulse cycle itself, so reload-to-zero plus the zero cycle spans one period.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)        cnt <= '0;
    else if (state != RUN)  cnt <= '0;
    else if (pfb_sync_o)    cnt <= reload;
    else if (!cnt_zero)     cnt <= cnt - PERIOD_W'(1);
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      pfb_sync_o   <= 1'b0;
      mux_sel_o    <= '0;
      sync_count_o <= '0;
    end else begin
      pfb_sync_o <= pulse;
      if (pulse) mux_sel_o <= sel_req;
      if (arm_rise)   sync_count_o <= '0;
      else if (pulse) sync_count_o <= sync_count_o + CNT_W'(1);
    end
  end

  assign armed_o   = (state == ARMED);
  assign running_o = (state == RUN);

endmodule
